// File: rtl/dm_cache_ctrl.sv
// Blocking direct-mapped cache controller: write-back or write-through,
// write-allocate, line-sized memory transfers, saturating hit/miss counters.
module dm_cache_ctrl #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int LINE_WORDS    = 4,
    parameter int NUM_LINES     = 16,
    parameter int WRITE_POLICY  = 1,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cpu_req_valid,
    output logic                                 cpu_req_ready,
    input  logic                                 cpu_req_we,
    input  logic [ADDRESS_WIDTH-1:0]             cpu_req_addr,
    input  logic [DATA_WIDTH-1:0]                cpu_req_wdata,
    output logic                                 cpu_resp_valid,
    output logic [DATA_WIDTH-1:0]                cpu_resp_rdata,
    output logic                                 cpu_resp_hit,
    output logic                                 mem_req_valid,
    input  logic                                 mem_req_ready,
    output logic                                 mem_req_we,
    output logic [ADDRESS_WIDTH-1:0]             mem_req_addr,
    output logic [LINE_WORDS*DATA_WIDTH-1:0]     mem_req_wdata,
    input  logic                                 mem_resp_valid,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0]     mem_resp_rdata,
    output logic [COUNT_WIDTH-1:0]               hit_count,
    output logic [COUNT_WIDTH-1:0]               miss_count
);

    localparam int LINE_W   = LINE_WORDS * DATA_WIDTH;
    localparam int BYTE_W   = $clog2(DATA_WIDTH / 8);
    localparam int WORD_W   = $clog2(LINE_WORDS);
    localparam int OFFSET_W = WORD_W + BYTE_W;
    localparam int INDEX_W  = $clog2(NUM_LINES);
    localparam int TAG_W    = ADDRESS_WIDTH - INDEX_W - OFFSET_W;
    localparam int WADDR_W  = ADDRESS_WIDTH - BYTE_W;
    localparam int DW_LOG   = $clog2(DATA_WIDTH);
    localparam int BIT_W    = WORD_W + DW_LOG;
    localparam bit WT       = (WRITE_POLICY == 0);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        REFILL,
        WT_WRITE
    } state_t;

    state_t state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    // Latched request; the address is kept as a word address.
    logic                  we_q;
    logic [WADDR_W-1:0]    addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  missed_q;

    logic                   resp_valid_q;
    logic [DATA_WIDTH-1:0]  resp_rdata_q;
    logic                   resp_hit_q;
    logic [COUNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [COUNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    logic                  accept;
    logic                  resp_fire;
    logic                  wr_hit;
    logic                  refill_en;
    logic                  cnt_hit;
    logic                  cnt_miss;
    logic                  mark_miss;
    logic                  hit;
    logic [INDEX_W-1:0]    idx;
    logic [TAG_W-1:0]      req_tag;
    logic [WORD_W-1:0]     word_idx;
    logic [BIT_W-1:0]      bit_off;
    logic [LINE_W-1:0]     cur_line;
    logic [LINE_W-1:0]     upd_line;
    logic [DATA_WIDTH-1:0] cur_word;
    logic                  unused_byte_bits;

    // Byte offset within a word never affects the lookup.
    assign unused_byte_bits = ^cpu_req_addr[BYTE_W-1:0];

    assign word_idx = addr_q[WORD_W-1:0];
    assign idx      = addr_q[WORD_W +: INDEX_W];
    assign req_tag  = addr_q[WORD_W+INDEX_W +: TAG_W];
    assign bit_off  = {word_idx, {DW_LOG{1'b0}}};
    assign cur_line = data_q[idx];
    assign cur_word = cur_line[bit_off +: DATA_WIDTH];
    assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);

    assign cpu_req_ready  = (state_q == IDLE);
    assign accept         = cpu_req_valid && cpu_req_ready;
    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_rdata = resp_rdata_q;
    assign cpu_resp_hit   = resp_hit_q;
    assign hit_count      = hit_cnt_q;
    assign miss_count     = miss_cnt_q;

    // Merge the latched store word into the currently indexed line.
    always_comb begin
        upd_line = cur_line;
        upd_line[bit_off +: DATA_WIDTH] = wdata_q;
    end

    // Next-state, memory request outputs and datapath strobes.
    always_comb begin
        state_d       = state_q;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        resp_fire     = 1'b0;
        wr_hit        = 1'b0;
        refill_en     = 1'b0;
        cnt_hit       = 1'b0;
        cnt_miss      = 1'b0;
        mark_miss     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_valid) state_d = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    cnt_hit = !missed_q;
                    wr_hit  = we_q;
                    if (we_q && WT) begin
                        state_d = WT_WRITE;
                    end else begin
                        resp_fire = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    cnt_miss  = !missed_q;
                    mark_miss = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) state_d = WRITEBACK;
                    else                              state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {tag_q[idx], idx, {OFFSET_W{1'b0}}};
                mem_req_wdata = cur_line;
                if (mem_req_ready) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, idx, {OFFSET_W{1'b0}}};
                if (mem_req_ready) state_d = REFILL;
            end
            REFILL: begin
                if (mem_resp_valid) begin
                    refill_en = 1'b1;
                    state_d   = COMPARE;
                end
            end
            WT_WRITE: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {req_tag, idx, {OFFSET_W{1'b0}}};
                mem_req_wdata = cur_line;
                if (mem_req_ready) begin
                    resp_fire = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating statistics counters.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (cnt_hit && (hit_cnt_q != '1))
            hit_cnt_d = hit_cnt_q + COUNT_WIDTH'(1);
        if (cnt_miss && (miss_cnt_q != '1))
            miss_cnt_d = miss_cnt_q + COUNT_WIDTH'(1);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Line valid/dirty status; a refill always lands clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (refill_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (wr_hit && !WT) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (refill_en) begin
            data_q[idx] <= mem_resp_rdata;
            tag_q[idx]  <= req_tag;
        end else if (wr_hit) begin
            data_q[idx] <= upd_line;
        end
    end

    // Request capture and the miss flag that marks the retry lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            missed_q <= 1'b0;
        end else if (accept) begin
            we_q     <= cpu_req_we;
            addr_q   <= cpu_req_addr[ADDRESS_WIDTH-1:BYTE_W];
            wdata_q  <= cpu_req_wdata;
            missed_q <= 1'b0;
        end else if (mark_miss) begin
            missed_q <= 1'b1;
        end
    end

    // One-cycle response pulse and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_hit_q   <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            resp_valid_q <= resp_fire;
            if (resp_fire) begin
                resp_rdata_q <= we_q ? wdata_q : cur_word;
                resp_hit_q   <= !missed_q;
            end
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench: write-back, write-through and narrow-counter instances
// driven by a vector table plus hand sequences for reset and saturation.
module tb_dm_cache_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst      [3];
    logic         c_valid  [3];
    logic         c_ready  [3];
    logic         c_we     [3];
    logic [31:0]  c_addr   [3];
    logic [31:0]  c_wdata  [3];
    logic         o_rv     [3];
    logic [31:0]  o_rdata  [3];
    logic         o_hit    [3];
    logic         m_valid  [3];
    logic         m_ready  [3];
    logic         m_we     [3];
    logic [31:0]  m_addr   [3];
    logic [127:0] m_wdata  [3];
    logic         m_rvalid [3];
    logic [127:0] m_rdata  [3];
    logic [31:0]  hc       [2];
    logic [31:0]  mc       [2];
    logic [3:0]   hc2;
    logic [3:0]   mc2;

    dm_cache_ctrl u_wb (
        .clk(clk), .rst(rst[0]),
        .cpu_req_valid(c_valid[0]), .cpu_req_ready(c_ready[0]),
        .cpu_req_we(c_we[0]), .cpu_req_addr(c_addr[0]),
        .cpu_req_wdata(c_wdata[0]),
        .cpu_resp_valid(o_rv[0]), .cpu_resp_rdata(o_rdata[0]),
        .cpu_resp_hit(o_hit[0]),
        .mem_req_valid(m_valid[0]), .mem_req_ready(m_ready[0]),
        .mem_req_we(m_we[0]), .mem_req_addr(m_addr[0]),
        .mem_req_wdata(m_wdata[0]),
        .mem_resp_valid(m_rvalid[0]), .mem_resp_rdata(m_rdata[0]),
        .hit_count(hc[0]), .miss_count(mc[0])
    );

    dm_cache_ctrl #(.WRITE_POLICY(0)) u_wt (
        .clk(clk), .rst(rst[1]),
        .cpu_req_valid(c_valid[1]), .cpu_req_ready(c_ready[1]),
        .cpu_req_we(c_we[1]), .cpu_req_addr(c_addr[1]),
        .cpu_req_wdata(c_wdata[1]),
        .cpu_resp_valid(o_rv[1]), .cpu_resp_rdata(o_rdata[1]),
        .cpu_resp_hit(o_hit[1]),
        .mem_req_valid(m_valid[1]), .mem_req_ready(m_ready[1]),
        .mem_req_we(m_we[1]), .mem_req_addr(m_addr[1]),
        .mem_req_wdata(m_wdata[1]),
        .mem_resp_valid(m_rvalid[1]), .mem_resp_rdata(m_rdata[1]),
        .hit_count(hc[1]), .miss_count(mc[1])
    );

    dm_cache_ctrl #(.COUNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst[2]),
        .cpu_req_valid(c_valid[2]), .cpu_req_ready(c_ready[2]),
        .cpu_req_we(c_we[2]), .cpu_req_addr(c_addr[2]),
        .cpu_req_wdata(c_wdata[2]),
        .cpu_resp_valid(o_rv[2]), .cpu_resp_rdata(o_rdata[2]),
        .cpu_resp_hit(o_hit[2]),
        .mem_req_valid(m_valid[2]), .mem_req_ready(m_ready[2]),
        .mem_req_we(m_we[2]), .mem_req_addr(m_addr[2]),
        .mem_req_wdata(m_wdata[2]),
        .mem_resp_valid(m_rvalid[2]), .mem_resp_rdata(m_rdata[2]),
        .hit_count(hc2), .miss_count(mc2)
    );

    typedef struct {
        int           d;
        bit           we;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        int           dly;
        logic [31:0]  rdata;
        bit           hit;
        int           lat;
        int           nwb;
        logic [31:0]  wb_addr;
        logic [127:0] wb_line;
        int           nrd;
        logic [31:0]  rd_addr;
        int           hits;
        int           misses;
    } vec_t;

    vec_t tbl [16];
    int   ntbl = 0;

    int checks = 0;
    int errors = 0;

    // Backing memory model, keyed by instance and line address.
    logic [127:0] mem [int];

    bit           got_done;
    logic [31:0]  got_rdata;
    bit           got_hit;
    int           got_lat;
    int           got_nwb;
    logic [31:0]  got_wb_addr;
    logic [127:0] got_wb_line;
    int           got_nrd;
    logic [31:0]  got_rd_addr;
    bit           got_rdy;
    int           got_stall;
    int           got_bad;

    function automatic int mkey(input int d, input logic [31:0] a);
        return d * 16777216 + int'(a);
    endfunction

    function automatic logic [127:0] mem_line(input int d, input logic [31:0] a);
        if (mem.exists(mkey(d, a))) return mem[mkey(d, a)];
        return {4{a}};
    endfunction

    function automatic int get_hits(input int d);
        if (d == 2) return int'(hc2);
        return int'(hc[d]);
    endfunction

    function automatic int get_misses(input int d);
        if (d == 2) return int'(mc2);
        return int'(mc[d]);
    endfunction

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic add(input int d, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input int dly,
                       input logic [31:0] rd, input bit h, input int lat,
                       input int nwb, input logic [31:0] wba,
                       input logic [127:0] wbl, input int nrd,
                       input logic [31:0] rda, input int hits,
                       input int misses);
        tbl[ntbl].d       = d;
        tbl[ntbl].we      = we;
        tbl[ntbl].addr    = a;
        tbl[ntbl].wdata   = wd;
        tbl[ntbl].dly     = dly;
        tbl[ntbl].rdata   = rd;
        tbl[ntbl].hit     = h;
        tbl[ntbl].lat     = lat;
        tbl[ntbl].nwb     = nwb;
        tbl[ntbl].wb_addr = wba;
        tbl[ntbl].wb_line = wbl;
        tbl[ntbl].nrd     = nrd;
        tbl[ntbl].rd_addr = rda;
        tbl[ntbl].hits    = hits;
        tbl[ntbl].misses  = misses;
        ntbl++;
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        repeat (2) @(negedge clk);
        rst[d] = 1'b0;
    endtask

    // Issue one request at a negedge and service memory until the response.
    task automatic run_req(input int d, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input int dly);
        int           t_acc;
        int           wait_n;
        bit           pend;
        logic [31:0]  pend_addr;
        bit           acc_now;
        bit           mhs_now;
        bit           prev_stall;
        logic [31:0]  hs_addr;
        logic         hs_we;
        logic [127:0] hs_wd;
        logic [31:0]  p_addr;
        logic         p_we;
        logic [127:0] p_wd;
        got_done = 0; got_rdata = '0; got_hit = 0; got_lat = 0;
        got_nwb = 0; got_wb_addr = '0; got_wb_line = '0;
        got_nrd = 0; got_rd_addr = '0; got_rdy = 0;
        got_stall = 0; got_bad = 0;
        t_acc = -1; wait_n = 0; pend = 0; pend_addr = '0;
        prev_stall = 0; p_addr = '0; p_we = 0; p_wd = '0;
        c_valid[d] = 1'b1;
        c_we[d]    = we;
        c_addr[d]  = a;
        c_wdata[d] = wd;
        for (int cyc = 0; cyc < 400; cyc++) begin
            acc_now = c_valid[d] && c_ready[d];
            mhs_now = m_valid[d] && m_ready[d];
            hs_addr = m_addr[d];
            hs_we   = m_we[d];
            hs_wd   = m_wdata[d];
            @(negedge clk);
            if (acc_now) begin
                c_valid[d] = 1'b0;
                t_acc = cyc;
            end
            if (mhs_now) begin
                if (hs_we) begin
                    got_nwb++;
                    got_wb_addr = hs_addr;
                    got_wb_line = hs_wd;
                    mem[mkey(d, hs_addr)] = hs_wd;
                end else begin
                    got_nrd++;
                    got_rd_addr = hs_addr;
                    pend = 1;
                    pend_addr = hs_addr;
                end
            end
            m_ready[d]  = 1'b0;
            m_rvalid[d] = 1'b0;
            if (o_rv[d]) begin
                got_done  = 1;
                got_rdata = o_rdata[d];
                got_hit   = o_hit[d];
                got_lat   = cyc - t_acc + 1;
                got_rdy   = c_ready[d];
                break;
            end
            if (t_acc >= 0 && c_ready[d]) got_bad++;
            if (pend) begin
                m_rvalid[d] = 1'b1;
                m_rdata[d]  = mem_line(d, pend_addr);
                pend = 0;
            end
            if (prev_stall && (!m_valid[d] || m_addr[d] !== p_addr ||
                               m_we[d] !== p_we || m_wdata[d] !== p_wd))
                got_bad++;
            prev_stall = 0;
            if (m_valid[d]) begin
                if (wait_n >= dly) begin
                    m_ready[d] = 1'b1;
                    wait_n = 0;
                end else begin
                    wait_n++;
                    got_stall++;
                    prev_stall = 1;
                    p_addr = m_addr[d];
                    p_we   = m_we[d];
                    p_wd   = m_wdata[d];
                end
            end
        end
        c_valid[d] = 1'b0;
    endtask

    function automatic string nm(input int i, input string s);
        return $sformatf("row%0d_%s", i, s);
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   seen;
        int   nresp;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; c_valid[d] = 1'b0; c_we[d] = 1'b0;
            c_addr[d] = '0; c_wdata[d] = '0; m_ready[d] = 1'b0;
            m_rvalid[d] = 1'b0; m_rdata[d] = '0;
        end
        mem[mkey(0, 32'h10)] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        mem[mkey(1, 32'h10)] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

        // Write-back instance.
        add(0, 0, 32'h10, 0, 0, 32'hAAAAAAAA, 0, 0, 0, 0, 0, 1, 32'h10, 0, 1);
        add(0, 0, 32'h14, 0, 0, 32'hBBBBBBBB, 1, 2, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 32'h1C, 0, 0, 32'hDDDDDDDD, 1, 2, 0, 0, 0, 0, 0, 2, 1);
        add(0, 1, 32'h10, 32'h12345678, 0, 32'h12345678, 1, 2,
            0, 0, 0, 0, 0, 3, 1);
        add(0, 0, 32'h110, 0, 0, 32'h00000110, 0, 0, 1, 32'h10,
            128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_12345678, 1, 32'h110, 3, 2);
        add(0, 0, 32'h13, 0, 0, 32'h12345678, 0, 0, 0, 0, 0, 1, 32'h10, 3, 3);
        add(0, 1, 32'h2C, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 0,
            0, 0, 0, 1, 32'h20, 3, 4);
        add(0, 0, 32'h24, 0, 0, 32'h00000020, 1, 2, 0, 0, 0, 0, 0, 4, 4);
        add(0, 0, 32'h22C, 0, 0, 32'h00000220, 0, 0, 1, 32'h20,
            128'hCAFEF00D_00000020_00000020_00000020, 1, 32'h220, 4, 5);
        add(0, 0, 32'h2C, 0, 5, 32'hCAFEF00D, 0, 0, 0, 0, 0, 1, 32'h20, 4, 6);
        // Write-through instance.
        add(1, 0, 32'h10, 0, 0, 32'hAAAAAAAA, 0, 0, 0, 0, 0, 1, 32'h10, 0, 1);
        add(1, 1, 32'h10, 32'h5A5A5A5A, 0, 32'h5A5A5A5A, 1, 3, 1, 32'h10,
            128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_5A5A5A5A, 0, 0, 1, 1);
        add(1, 0, 32'h110, 0, 0, 32'h00000110, 0, 0, 0, 0, 0, 1, 32'h110, 1, 2);
        add(1, 0, 32'h10, 0, 0, 32'h5A5A5A5A, 0, 0, 0, 0, 0, 1, 32'h10, 1, 3);
        add(1, 1, 32'h24, 32'h77, 0, 32'h77, 0, 0, 1, 32'h20,
            128'h00000020_00000020_00000077_00000020, 1, 32'h20, 1, 4);

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        @(negedge clk);

        chk("rst_ready", 128'(c_ready[0]), 128'(1));
        chk("rst_resp_valid", 128'(o_rv[0]), 128'(0));
        chk("rst_resp_hit", 128'(o_hit[0]), 128'(0));
        chk("rst_resp_rdata", 128'(o_rdata[0]), 128'(0));
        chk("rst_mem_valid", 128'(m_valid[0]), 128'(0));
        chk("rst_mem_we", 128'(m_we[0]), 128'(0));
        chk("rst_mem_addr", 128'(m_addr[0]), 128'(0));
        chk("rst_mem_wdata", m_wdata[0], 128'(0));
        chk("rst_hits", 128'(get_hits(0)), 128'(0));
        chk("rst_misses", 128'(get_misses(0)), 128'(0));

        for (int i = 0; i < ntbl; i++) begin
            v = tbl[i];
            run_req(v.d, v.we, v.addr, v.wdata, v.dly);
            chk(nm(i, "done"), 128'(got_done), 128'(1));
            chk(nm(i, "rdata"), 128'(got_rdata), 128'(v.rdata));
            chk(nm(i, "hit"), 128'(got_hit), 128'(v.hit));
            if (v.lat != 0)
                chk(nm(i, "latency"), 128'(got_lat), 128'(v.lat));
            chk(nm(i, "n_mem_wr"), 128'(got_nwb), 128'(v.nwb));
            if (v.nwb > 0) begin
                chk(nm(i, "wr_addr"), 128'(got_wb_addr), 128'(v.wb_addr));
                chk(nm(i, "wr_line"), got_wb_line, v.wb_line);
            end
            chk(nm(i, "n_mem_rd"), 128'(got_nrd), 128'(v.nrd));
            if (v.nrd > 0)
                chk(nm(i, "rd_addr"), 128'(got_rd_addr), 128'(v.rd_addr));
            chk(nm(i, "hits"), 128'(get_hits(v.d)), 128'(v.hits));
            chk(nm(i, "misses"), 128'(get_misses(v.d)), 128'(v.misses));
            chk(nm(i, "ready_at_resp"), 128'(got_rdy), 128'(1));
            chk(nm(i, "busy_stable"), 128'(got_bad), 128'(0));
            if (v.dly > 0)
                chk(nm(i, "stalled"), 128'(got_stall >= v.dly), 128'(1));
            @(negedge clk);
            chk(nm(i, "resp_pulse"), 128'(o_rv[v.d]), 128'(0));
        end

        // Reset while waiting for the refill data.
        do_reset(0);
        c_valid[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h10;
        @(negedge clk);
        c_valid[0] = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (m_valid[0]) seen = 1;
        end
        chk("rr_alloc_seen", 128'(seen), 128'(1));
        m_ready[0] = 1'b1;
        @(negedge clk);
        m_ready[0] = 1'b0;
        chk("rr_refill_mem_valid", 128'(m_valid[0]), 128'(0));
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("rr_mem_valid_dropped", 128'(m_valid[0]), 128'(0));
        chk("rr_ready", 128'(c_ready[0]), 128'(1));
        nresp = 0;
        m_rvalid[0] = 1'b1;
        m_rdata[0]  = 128'h1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_rv[0] || m_valid[0]) nresp++;
        end
        m_rvalid[0] = 1'b0;
        chk("rr_no_resp", 128'(nresp), 128'(0));
        chk("rr_misses_cleared", 128'(get_misses(0)), 128'(0));
        run_req(0, 0, 32'h10, 0, 0);
        chk("rr_reread_done", 128'(got_done), 128'(1));
        chk("rr_reread_hit", 128'(got_hit), 128'(0));
        chk("rr_reread_rd", 128'(got_nrd), 128'(1));
        chk("rr_reread_rdata", 128'(got_rdata), 128'(32'h12345678));
        chk("rr_reread_misses", 128'(get_misses(0)), 128'(1));

        // Miss counter saturation on a 4-bit instance.
        for (int t = 0; t < 17; t++) begin
            run_req(2, 0, 32'(t) << 8, 0, 0);
            if (t == 13)
                chk("sat_misses_14", 128'(get_misses(2)), 128'(14));
        end
        chk("sat_done", 128'(got_done), 128'(1));
        chk("sat_misses_15", 128'(get_misses(2)), 128'(15));
        run_req(2, 0, 32'h1004, 0, 0);
        chk("sat_hit", 128'(got_hit), 128'(1));
        chk("sat_hit_rdata", 128'(got_rdata), 128'(32'h1000));
        chk("sat_hits", 128'(get_hits(2)), 128'(1));
        chk("sat_misses_hold", 128'(get_misses(2)), 128'(15));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
